control_unit: RTL and testbench

- Multi-cycle FSM sequencer for the 8-bit CPU. It sits directly upstream of the datapath.
- Consumes the datapath's decoded opcode and its ALU flags.
- Drives the datapath load/increment strobes and the memory read/write handshake.
- Provides run/single-step control, a memory wait timeout, illegal-opcode detection and a retired-instruction counter.

---
 rtl/control_unit.sv | 189 ++++++++++++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle sequencer for the 8-bit CPU. Walks each instruction through
// FETCH / DECODE / (ADDR / READ | WRITE) / EXEC | BRANCH / RETIRE, drives the
// datapath load strobes and the memory read/write handshake, and watches for
// memory stalls, undefined opcodes and the HLT instruction.
//
// Ports
//   clk, reset_n            : rising-edge clock, asynchronous active-low reset
//   run, step               : free-run level / single-instruction pulse from IDLE
//   opcode                  : instruction[7:4] from the datapath IR
//   zero_flag, carry_flag   : live ALU flags, captured during EXEC
//   mem_ready               : memory finishes the current access this cycle
//   ir_load, pc_inc,
//   pc_load, mar_load,
//   mdr_load, acc_load      : datapath strobes
//   mem_rd, mem_wr, addr_sel: memory request and address-source select
//   halted, bus_error       : HALT state indicator / sticky memory-timeout flag
//   illegal_op              : one-cycle pulse on an undefined opcode
//   instr_count             : retired-instruction counter (wraps)
//   state_dbg               : current state encoding
module control_unit #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_load,
  output logic             mdr_load,
  output logic             acc_load,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_READ   = 4'd4,
    S_WRITE  = 4'd5,
    S_EXEC   = 4'd6,
    S_BRANCH = 4'd7,
    S_RETIRE = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JC    = 4'hB;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // Timeout fires on the WAIT_LIMIT-th consecutive stalled cycle, i.e. when
  // the counter already holds WAIT_LIMIT-1 stalls and this cycle stalls too.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t     state, next_state;
  logic [3:0] op_q;
  logic       z_q, c_q;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       timeout;

  assign mem_state = (state == S_FETCH) || (state == S_READ) || (state == S_WRITE);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // Next-state logic. DECODE routes on the opcode input because op_q only
  // takes that value at the end of the DECODE cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run || step) next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_LOAD, OP_STORE: next_state = S_ADDR;
          OP_NOT, OP_SHL, OP_SHR:                    next_state = S_EXEC;
          OP_JMP, OP_JZ, OP_JC:                      next_state = S_BRANCH;
          OP_HLT:                                    next_state = S_HALT;
          default:                                   next_state = S_RETIRE;
        endcase
      end
      S_ADDR:   next_state = (op_q == OP_STORE) ? S_WRITE : S_READ;
      S_READ:   if (mem_ready) next_state = S_EXEC;
                else if (timeout) next_state = S_HALT;
      S_WRITE:  if (mem_ready) next_state = S_RETIRE;
                else if (timeout) next_state = S_HALT;
      S_EXEC:   next_state = S_RETIRE;
      S_BRANCH: next_state = S_RETIRE;
      S_RETIRE: next_state = run ? S_FETCH : S_IDLE;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output decode. Everything is Moore except the three strobes that must
  // coincide with the memory completing its access. illegal_op looks at the
  // opcode input directly; it comes from the IR, which is stable in DECODE.
  always_comb begin
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    mdr_load   = 1'b0;
    acc_load   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: illegal_op = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
      S_ADDR:   mar_load = 1'b1;
      S_READ: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        mdr_load = mem_ready;
      end
      S_WRITE: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
      end
      S_EXEC:   acc_load = 1'b1;
      S_BRANCH: pc_load = (op_q == OP_JMP) || ((op_q == OP_JZ) && z_q) ||
                          ((op_q == OP_JC) && c_q);
      default: ;
    endcase
  end

  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  // State register plus the registered side-state: latched opcode, flags
  // captured in EXEC (branches only ever see these), the memory stall
  // counter, the sticky bus error and the retired-instruction count.
  // The stall counter is zero whenever a memory state is entered because
  // every path into FETCH/READ/WRITE comes from a non-memory state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= 4'h0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      wait_cnt    <= 8'd0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= opcode;
      if (state == S_EXEC) begin
        z_q <= zero_flag;
        c_q <= carry_flag;
      end
      if (mem_state && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
      else                         wait_cnt <= 8'd0;
      if (timeout) bus_error <= 1'b1;
      if (state == S_RETIRE) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Directed bench for control_unit: reset latency trace, per-instruction
// strobe/latency table with a small memory responder, single-step, HLT,
// illegal opcode, memory timeout and asynchronous reset mid-READ.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run, step;
  logic [3:0]  opcode;
  logic        zero_flag, carry_flag, mem_ready;
  logic        ir_load, pc_inc, pc_load, mar_load, mdr_load, acc_load;
  logic        mem_rd, mem_wr, addr_sel, halted, bus_error, illegal_op;
  logic [15:0] instr_count;
  logic [3:0]  state_dbg;

  int chk_cnt = 0;
  int err_cnt = 0;

  int n_cyc, n_mar, n_mdr, n_acc, n_pc, n_wr, n_ill, n_ir, n_conflict;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_HALT = 4'd9;
  localparam logic [3:0] ST_READ = 4'd4, ST_RETIRE = 4'd8;

  control_unit #(.WAIT_LIMIT(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .step(step), .opcode(opcode),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .mdr_load(mdr_load), .acc_load(acc_load), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr_sel(addr_sel), .halted(halted), .bus_error(bus_error),
    .illegal_op(illegal_op), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'h0;
    zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  // Runs one instruction starting in FETCH. A tiny memory answers fetches
  // immediately and operand accesses after 'wt' stalled cycles. Ends after
  // the RETIRE cycle (or on reaching HALT) and leaves counts in n_*.
  task automatic applyStimulus(input logic [3:0] op, input int wt, input logic zf,
                               input logic cf, input logic rn, input int step_at);
    int  req;
    logic done;
    req = 0;
    n_cyc = 0; n_mar = 0; n_mdr = 0; n_acc = 0; n_pc = 0; n_wr = 0;
    n_ill = 0; n_ir = 0; n_conflict = 0;
    run = rn;
    for (int k = 0; k < 60; k++) begin
      opcode = op; zero_flag = zf; carry_flag = cf;
      step = (k == step_at);
      mem_ready = (mem_rd || mem_wr) && (!addr_sel || req >= wt);
      #1;
      n_cyc++;
      n_mar += int'(mar_load); n_mdr += int'(mdr_load); n_acc += int'(acc_load);
      n_pc += int'(pc_load); n_wr += int'(mem_wr); n_ill += int'(illegal_op);
      n_ir += int'(ir_load);
      if ((int'(ir_load) + int'(mar_load) + int'(mdr_load) + int'(acc_load) +
           int'(pc_load)) > 1 || (mem_rd && mem_wr))
        n_conflict++;
      done = (state_dbg == ST_RETIRE) || halted;
      if ((mem_rd || mem_wr) && !mem_ready) req++;
      else req = 0;
      cyc();
      if (done) break;
    end
    step = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic [3:0] op, input int wt,
                         input logic zf, input logic cf, input logic rn,
                         input int e_cyc, input int e_mar, input int e_mdr,
                         input int e_acc, input int e_pc, input int e_wr, input int e_ill);
    applyStimulus(op, wt, zf, cf, rn, -1);
    checkOutput({tag, " cycles"}, n_cyc, e_cyc);
    checkOutput({tag, " mar_load"}, n_mar, e_mar);
    checkOutput({tag, " mdr_load"}, n_mdr, e_mdr);
    checkOutput({tag, " acc_load"}, n_acc, e_acc);
    checkOutput({tag, " pc_load"}, n_pc, e_pc);
    checkOutput({tag, " mem_wr cycles"}, n_wr, e_wr);
    checkOutput({tag, " illegal_op"}, n_ill, e_ill);
    checkOutput({tag, " ir_load"}, n_ir, 1);
    checkOutput({tag, " strobe conflict"}, n_conflict, 0);
  endtask

  int exp_state [6] = '{1, 2, 3, 4, 6, 8};
  int n_rd;

  initial begin
    // Reset held with run=1: nothing may move.
    reset_n = 1'b0; run = 1'b1; step = 1'b0; opcode = 4'h4;
    zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b1;
    #3;
    checkOutput("reset state", state_dbg, ST_IDLE);
    checkOutput("reset mem_rd", mem_rd, 0);
    checkOutput("reset ir_load", ir_load, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset bus_error", bus_error, 0);
    checkOutput("reset instr_count", instr_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // LOAD 4, zero-wait memory, cycle-by-cycle strobe trace.
    for (int c = 1; c <= 6; c++) begin
      cyc();
      checkOutput($sformatf("load c%0d state", c), state_dbg, exp_state[c-1]);
      checkOutput($sformatf("load c%0d ir_load", c), ir_load, (c == 1));
      checkOutput($sformatf("load c%0d pc_inc", c), pc_inc, (c == 1));
      checkOutput($sformatf("load c%0d mar_load", c), mar_load, (c == 3));
      checkOutput($sformatf("load c%0d mdr_load", c), mdr_load, (c == 4));
      checkOutput($sformatf("load c%0d acc_load", c), acc_load, (c == 5));
    end
    cyc();
    checkOutput("load retired count", instr_count, 1);
    checkOutput("load back to fetch", state_dbg, ST_FETCH);

    //        tag         op    wt zf cf run cyc mar mdr acc pc wr ill
    runCase("nop",        4'h0, 0, 0, 0, 1,  3,  0,  0,  0,  0, 0, 0);
    runCase("store wait", 4'h5, 3, 0, 0, 1,  8,  1,  0,  0,  0, 4, 0);
    runCase("add z=1",    4'h1, 0, 1, 0, 1,  6,  1,  1,  1,  0, 0, 0);
    runCase("jz taken",   4'hA, 0, 0, 0, 1,  4,  0,  0,  0,  1, 0, 0);
    runCase("add z=0",    4'h1, 0, 0, 0, 1,  6,  1,  1,  1,  0, 0, 0);
    runCase("jz not",     4'hA, 0, 1, 0, 1,  4,  0,  0,  0,  0, 0, 0);
    runCase("jmp",        4'h9, 0, 0, 0, 1,  4,  0,  0,  0,  1, 0, 0);
    runCase("shl c=1",    4'h7, 0, 0, 1, 1,  4,  0,  0,  1,  0, 0, 0);
    runCase("jc taken",   4'hB, 0, 0, 0, 1,  4,  0,  0,  0,  1, 0, 0);
    runCase("load wait",  4'h4, 2, 0, 0, 1,  8,  1,  1,  1,  0, 0, 0);
    runCase("illegal",    4'hC, 0, 0, 0, 0,  3,  0,  0,  0,  0, 0, 1);
    checkOutput("count after table", instr_count, 12);
    checkOutput("run=0 stops in idle", state_dbg, ST_IDLE);

    // Single step; a second step pulse mid-instruction must be ignored.
    step = 1'b1;
    cyc();
    step = 1'b0;
    checkOutput("step enters fetch", state_dbg, ST_FETCH);
    applyStimulus(4'h1, 0, 0, 0, 1'b0, 2);
    checkOutput("step add cycles", n_cyc, 6);
    checkOutput("step back to idle", state_dbg, ST_IDLE);
    checkOutput("step count", instr_count, 13);
    cyc(); cyc(); cyc();
    checkOutput("step stays idle", state_dbg, ST_IDLE);
    checkOutput("step count stable", instr_count, 13);

    // HLT: terminal and not counted.
    run = 1'b1;
    cyc();
    applyStimulus(4'hF, 0, 0, 0, 1'b1, -1);
    checkOutput("hlt cycles", n_cyc, 3);
    checkOutput("hlt halted", halted, 1);
    checkOutput("hlt count", instr_count, 13);
    cyc(); cyc();
    checkOutput("hlt stays", state_dbg, ST_HALT);

    // Memory timeout in FETCH.
    doReset();
    checkOutput("reset clears halted", halted, 0);
    checkOutput("reset clears count", instr_count, 0);
    run = 1'b1; mem_ready = 1'b0;
    n_rd = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      n_rd += int'(mem_rd);
      if (halted) break;
    end
    checkOutput("timeout mem_rd cycles", n_rd, 16);
    checkOutput("timeout bus_error", bus_error, 1);
    checkOutput("timeout halted", halted, 1);
    checkOutput("timeout mem_rd dropped", mem_rd, 0);
    mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    checkOutput("timeout stays halted", state_dbg, ST_HALT);
    checkOutput("timeout no ir_load", ir_load, 0);
    checkOutput("timeout sticky", bus_error, 1);

    // Asynchronous reset in the middle of READ.
    doReset();
    checkOutput("reset clears bus_error", bus_error, 0);
    run = 1'b1; mem_ready = 1'b1; opcode = 4'h4;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    checkOutput("pre-reset state read", state_dbg, ST_READ);
    checkOutput("pre-reset mem_rd", mem_rd, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset state", state_dbg, ST_IDLE);
    checkOutput("async reset mem_rd", mem_rd, 0);
    checkOutput("async reset addr_sel", addr_sel, 0);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
